// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a walking-one scan sequencer.
// Index is loaded directly or stepped up/down at a programmable dwell.
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      s,
  input  logic                  load,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] d,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap,
  output logic                  busy
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_DOWN   = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;

  logic scan_up;
  logic scan_dn;
  logic restart;

  assign scan_up = (mode == M_UP);
  assign scan_dn = (mode == M_DOWN);
  // Activation and mode change both restart the dwell without stepping.
  assign restart = (state_q == IDLE) || (mode != mode_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      state_d = ACTIVE;
      mode_d  = mode;
      if (load) begin
        idx_d = s;
        cnt_d = '0;
      end else if (restart) begin
        cnt_d = '0;
      end else if (scan_up || scan_dn) begin
        if (cnt_q == dwell) begin
          cnt_d = '0;
          if (scan_up) begin
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == '1);
          end else begin
            idx_d  = idx_q - 1'b1;
            wrap_d = (idx_q == '0);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs derive from next state so all of them change on one edge.
  always_comb begin
    d_d = '0;
    if (state_d == ACTIVE) begin
      d_d[idx_d] = 1'b1;
    end
  end

  always_comb begin
    busy_d = 1'b0;
    if (state_d == ACTIVE) begin
      unique case (1'b1)
        (mode_d == M_UP):     busy_d = 1'b1;
        (mode_d == M_DOWN):   busy_d = 1'b1;
        (mode_d == M_DIRECT): busy_d = 1'b0;
        (mode_d == M_HOLD):   busy_d = 1'b0;
        default:              busy_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= M_DIRECT;
      d_q     <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder.
// Expected outputs are queued per cycle and popped after each edge.
module tb_onehot_scan_decoder;

  typedef struct packed {
    logic       act;
    logic [3:0] idx;
    logic       wrap;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] s_in;
  logic       load;
  logic [7:0] dwell;

  logic [7:0]  d3;
  logic [2:0]  idx3;
  logic        wrap3, busy3;
  logic [3:0]  d2;
  logic [1:0]  idx2;
  logic        wrap2, busy2;
  logic [15:0] d4;
  logic [3:0]  idx4;
  logic        wrap4, busy4;

  int n_chk;
  int n_fail;
  string ph;

  exp_t       q3[$];
  logic [3:0] qi2[$];
  logic [3:0] qi4[$];

  onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .s(s_in[2:0]), .load(load), .dwell(dwell),
    .d(d3), .idx(idx3), .wrap(wrap3), .busy(busy3)
  );

  onehot_scan_decoder #(.SEL_W(2), .DWELL_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .s(s_in[1:0]), .load(load), .dwell(dwell),
    .d(d2), .idx(idx2), .wrap(wrap2), .busy(busy2)
  );

  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .s(s_in), .load(load), .dwell(dwell),
    .d(d4), .idx(idx4), .wrap(wrap4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", ph, tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic a, input int i,
                              input logic w, input logic b);
    exp_t e;
    e.act  = a;
    e.idx  = 4'(i);
    e.wrap = w;
    e.busy = b;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    logic [31:0] ed;
    logic [3:0] i;
    chk("sb_depth", 32'(q3.size()), 32'd1);
    if (q3.size() != 0) begin
      e  = q3.pop_front();
      ed = e.act ? (32'd1 << e.idx) : 32'd0;
      chk("d", 32'(d3), ed);
      chk("idx", 32'(idx3), 32'(e.idx));
      chk("wrap", 32'(wrap3), 32'(e.wrap));
      chk("busy", 32'(busy3), 32'(e.busy));
    end
    if (qi2.size() != 0) begin
      i = qi2.pop_front();
      chk("d2", 32'(d2), 32'd1 << i);
      chk("idx2", 32'(idx2), 32'(i));
    end
    if (qi4.size() != 0) begin
      i = qi4.pop_front();
      chk("d4", 32'(d4), 32'd1 << i);
      chk("idx4", 32'(idx4), 32'(i));
    end
  endtask

  task automatic cyc(input exp_t e);
    q3.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic chk_zero();
    chk("d", 32'(d3), 32'd0);
    chk("idx", 32'(idx3), 32'd0);
    chk("wrap", 32'(wrap3), 32'd0);
    chk("busy", 32'(busy3), 32'd0);
  endtask

  initial begin
    int up_i[9];
    bit up_w[9];
    int dn_i[9];
    bit dn_w[9];
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 2'b00;
    s_in   = 4'd0;
    load   = 1'b0;
    dwell  = 8'd0;

    ph = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    enable = 1'b0;
    rst_n  = 1'b1;
    ph = "idle";
    cyc(mk(0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0));

    ph = "direct";
    enable = 1'b1;
    load   = 1'b1;
    for (int s = 0; s < 16; s++) begin
      s_in = 4'(s);
      qi2.push_back(4'(s % 4));
      qi4.push_back(4'(s));
      cyc(mk(1, s % 8, 0, 0));
    end
    load = 1'b0;
    s_in = 4'd2;
    qi2.push_back(4'd3);
    qi4.push_back(4'd15);
    cyc(mk(1, 7, 0, 0));

    ph = "scan_up";
    mode  = 2'b01;
    dwell = 8'd2;
    s_in  = 4'd6;
    load  = 1'b1;
    cyc(mk(1, 6, 0, 1));
    load = 1'b0;
    up_i = '{6, 6, 7, 7, 7, 0, 0, 0, 1};
    up_w = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int k = 0; k < 9; k++) cyc(mk(1, up_i[k], up_w[k], 1));

    ph = "scan_dn";
    mode  = 2'b10;
    dwell = 8'd0;
    s_in  = 4'd1;
    load  = 1'b1;
    cyc(mk(1, 1, 0, 1));
    load = 1'b0;
    dn_i = '{0, 7, 6, 5, 4, 3, 2, 1, 0};
    dn_w = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++) cyc(mk(1, dn_i[k], dn_w[k], 1));

    ph = "load_vs_step";
    s_in = 4'd6;
    load = 1'b1;
    cyc(mk(1, 6, 0, 1));
    load = 1'b0;
    cyc(mk(1, 5, 0, 1));

    ph = "mode_chg";
    mode  = 2'b01;
    dwell = 8'd3;
    cyc(mk(1, 5, 0, 1));
    cyc(mk(1, 5, 0, 1));
    cyc(mk(1, 5, 0, 1));
    mode = 2'b11;
    cyc(mk(1, 5, 0, 0));
    for (int k = 0; k < 3; k++) cyc(mk(1, 5, 0, 0));
    mode = 2'b01;
    cyc(mk(1, 5, 0, 1));
    for (int k = 0; k < 3; k++) cyc(mk(1, 5, 0, 1));
    cyc(mk(1, 6, 0, 1));

    ph = "enable";
    dwell = 8'd1;
    s_in  = 4'd5;
    load  = 1'b1;
    cyc(mk(1, 5, 0, 1));
    load = 1'b0;
    cyc(mk(1, 5, 0, 1));
    enable = 1'b0;
    cyc(mk(0, 5, 0, 0));
    cyc(mk(0, 5, 0, 0));
    enable = 1'b1;
    cyc(mk(1, 5, 0, 1));
    cyc(mk(1, 5, 0, 1));
    cyc(mk(1, 6, 0, 1));
    cyc(mk(1, 6, 0, 1));
    cyc(mk(1, 7, 0, 1));

    ph = "async_rst";
    dwell = 8'd3;
    cyc(mk(1, 7, 0, 1));
    rst_n = 1'b0;
    #2;
    chk_zero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(mk(1, 0, 0, 1));
    cyc(mk(1, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
